con_bus_arbiter: RTL and testbench
==================================

Name: con_bus_arbiter

Overview:
Arbitrates ownership and direction of the shared bidirectional con_1..con_3 bus between two requesters. The inbound loader moves feature/kernel data from the testbench into the accelerator. The outbound writer drives results out of the accelerator. The block sits in the accelerator top, drives dut_driving_cons, enforces turnaround dead cycles on every direction change, and bounds burst length so neither side starves.

Parameters:
MAX_BURST, 16, max beats per grant while the other side is requesting (>=1)
TURNAROUND_CYCLES, 1, dead cycles inserted on every direction change (>=1)
OUT_PRIORITY, 1, 1: outbound wins simultaneous requests from IDLE; 0: inbound wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
running  in  1  accelerator active; arbitration only while high
in_req  in  1  inbound loader has data to accept
in_beat  in  1  inbound transfer completed this cycle (con_valid && con_ready)
out_req  in  1  outbound writer has results pending
out_beat  in  1  outbound transfer completed this cycle (output_valid)
in_grant  out  1  inbound owns bus; gates con_ready externally
out_grant  out  1  outbound owns bus; writer may drive and assert output_valid
dut_driving_cons  out  1  1 = accelerator drives con_1..3, 0 = high-Z from accelerator
turnaround  out  1  high during dead cycles
beat_cnt  out  $clog2(MAX_BURST+1)  beats in current grant
protocol_err  out  1  sticky: beat seen without matching grant

Behaviour:
- All outputs registered. Reset (sync, rst=1 at posedge): state IDLE, dir=IN, all outputs 0.
- States: IDLE, IN_GRANT, TURN_TO_OUT, OUT_GRANT, TURN_TO_IN. Turn counter counts TURNAROUND_CYCLES-1 down to 0.
- IDLE (both grants 0):
  - If running=0, stay.
  - Winner: out_req&&(OUT_PRIORITY||!in_req) selects OUT, else in_req selects IN.
  - Winner equal to dir: go straight to the grant state; grant is high the next cycle (1-cycle latency req->grant).
  - Winner not equal to dir: go to the TURN state.
- TURN_TO_OUT:
  - dut_driving_cons=1 from the first dead cycle (inbound driver released), turnaround=1, grants 0.
  - After TURNAROUND_CYCLES cycles go to OUT_GRANT, dir=OUT.
- TURN_TO_IN:
  - dut_driving_cons stays 1 through the dead cycles, turnaround=1.
  - On entry to IN_GRANT, dut_driving_cons=0 and dir=IN.
- IN_GRANT (in_grant=1, dut_driving_cons=0):
  - beat_cnt increments on in_beat.
  - Exit to TURN_TO_OUT when in_beat && beat_cnt==MAX_BURST-1 && out_req.
  - Else exit to IDLE when in_req=0 and no in_beat this cycle.
  - At MAX_BURST with out_req=0, beat_cnt wraps to 0 and the grant continues.
- OUT_GRANT: mirror of IN_GRANT using out_beat/out_req/in_req, exiting to TURN_TO_IN. dut_driving_cons=1 throughout.
- beat_cnt clears to 0 on every grant entry and in IDLE/TURN states.
- Direction persists through IDLE. No dead cycles when the same direction is regranted.
- Simultaneous req drop and beat: the beat is counted and the grant held one more cycle.
- running falls in any state: next cycle IDLE, grants 0, turnaround 0, dut_driving_cons 0, dir=IN. An in-flight beat on that cycle is still counted, then cleared.
- protocol_err set on (in_beat && !in_grant) || (out_beat && !out_grant) || (in_beat && out_beat). Cleared only by rst.
- rst during any state: next cycle identical to the post-reset state.
- Invariant: in_grant && out_grant never both 1; grant and turnaround never both 1.

Decomposition:
- Shared package:
  - typedef enum for bus state: ST_IDLE, ST_IN_GRANT, ST_TURN_OUT, ST_OUT_GRANT, ST_TURN_IN.
  - typedef for dir: DIR_IN, DIR_OUT.
  - Default MAX_BURST and TURNAROUND_CYCLES constants, added to config_t alongside DATA_WIDTH.
- One natural sub-module: con_burst_counter (beat counter with clear, wrap at MAX_BURST and terminal-count flag). FSM and turn counter stay in the top.

Test Plan:
- Reset/idle: rst=1 then running=1, no reqs, 20 cycles -> all outputs 0, state IDLE, protocol_err 0.
- Inbound only: in_req=1 with in_beat every cycle for 40 beats, out_req=0 -> in_grant 1 cycle after in_req, beat_cnt wraps 15->0 twice, dut_driving_cons stays 0, no turnaround.
- Fairness/turnaround, MAX_BURST=16, TURNAROUND_CYCLES=2:
  - Start: in_req held with continuous in_beat, out_req asserted at beat 5.
  - Inbound side: in_grant drops after the 16th beat, then 2 cycles turnaround=1 with dut_driving_cons=1.
  - Outbound side: out_grant rises next and serves up to 16 beats, then TURN_TO_IN if in_req is still high.
- Tie from IDLE: in_req and out_req rise in the same cycle.
  - OUT_PRIORITY=1: TURN_TO_OUT, then out_grant.
  - OUT_PRIORITY=0: in_grant 1 cycle later with no dead cycles.
- running drop mid-OUT_GRANT at beat 7 -> next cycle grants 0, dut_driving_cons 0, beat_cnt 0. A new in_req after running=1 is granted with no turnaround.
- Protocol error: in_beat pulsed while out_grant=1 -> protocol_err=1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/con_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// con_bus_arbiter_pkg : shared types and defaults for the con bus arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package con_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IN_GRANT  = 3'd1,
    ST_TURN_OUT  = 3'd2,
    ST_OUT_GRANT = 3'd3,
    ST_TURN_IN   = 3'd4
  } bus_state_e;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } bus_dir_e;

  localparam int unsigned DEFAULT_DATA_WIDTH        = 8;
  localparam int unsigned DEFAULT_MAX_BURST         = 16;
  localparam int unsigned DEFAULT_TURNAROUND_CYCLES = 1;

  typedef struct packed {
    int unsigned data_width;
    int unsigned max_burst;
    int unsigned turnaround_cycles;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    data_width:        DEFAULT_DATA_WIDTH,
    max_burst:         DEFAULT_MAX_BURST,
    turnaround_cycles: DEFAULT_TURNAROUND_CYCLES
  };

  function automatic logic is_grant(input bus_state_e s);
    return (s == ST_IN_GRANT) || (s == ST_OUT_GRANT);
  endfunction

endpackage : con_bus_arbiter_pkg

`default_nettype wire

// File: rtl/con_burst_counter.sv
// ---------------------------------------------------------------------------
// con_burst_counter : per-grant beat counter, wraps at MAX_BURST, flags TC
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module con_burst_counter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule : con_burst_counter

`default_nettype wire

// File: rtl/con_bus_arbiter.sv
// ---------------------------------------------------------------------------
// con_bus_arbiter : direction/ownership arbiter for the shared con_1..3 bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module con_bus_arbiter
  import con_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST         = DEFAULT_CFG.max_burst,
  parameter int unsigned TURNAROUND_CYCLES = DEFAULT_CFG.turnaround_cycles,
  parameter bit          OUT_PRIORITY      = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           running,
  input  logic                           in_req,
  input  logic                           in_beat,
  input  logic                           out_req,
  input  logic                           out_beat,
  output logic                           in_grant,
  output logic                           out_grant,
  output logic                           dut_driving_cons,
  output logic                           turnaround,
  output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt,
  output logic                           protocol_err
);

  localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
  localparam int unsigned   TW        = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND_CYCLES - 1);

  bus_state_e    state_q, state_d;
  bus_dir_e      dir_q, dir_d;
  logic [TW-1:0] turn_q, turn_d;

  logic in_grant_q, in_grant_d;
  logic out_grant_q, out_grant_d;
  logic drive_q, drive_d;
  logic turn_flag_q, turn_flag_d;
  logic perr_q, perr_d;

  logic          w_out_wins;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_tc;
  logic [CW-1:0] w_cnt;

  assign w_out_wins = out_req && (OUT_PRIORITY || !in_req);

  // Counter restarts on every grant entry and whenever no grant is held.
  assign w_cnt_clr = !is_grant(state_d) || (state_d != state_q);
  assign w_cnt_inc = (state_q == ST_IN_GRANT) ? in_beat : out_beat;

  con_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_burst_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_cnt_clr),
    .inc_i (w_cnt_inc),
    .cnt_o (w_cnt),
    .tc_o  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_IN;
      turn_q      <= '0;
      in_grant_q  <= 1'b0;
      out_grant_q <= 1'b0;
      drive_q     <= 1'b0;
      turn_flag_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      turn_q      <= turn_d;
      in_grant_q  <= in_grant_d;
      out_grant_q <= out_grant_d;
      drive_q     <= drive_d;
      turn_flag_q <= turn_flag_d;
      perr_q      <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    turn_d  = turn_q;
    if (!running) begin
      state_d = ST_IDLE;
      dir_d   = DIR_IN;
      turn_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_out_wins) begin
            if (dir_q == DIR_OUT) begin
              state_d = ST_OUT_GRANT;
            end else begin
              state_d = ST_TURN_OUT;
              turn_d  = TURN_LOAD;
            end
          end else if (in_req) begin
            if (dir_q == DIR_IN) begin
              state_d = ST_IN_GRANT;
            end else begin
              state_d = ST_TURN_IN;
              turn_d  = TURN_LOAD;
            end
          end
        end
        ST_IN_GRANT: begin
          if (in_beat && w_tc && out_req) begin
            state_d = ST_TURN_OUT;
            turn_d  = TURN_LOAD;
          end else if (!in_req && !in_beat) begin
            state_d = ST_IDLE;
          end
        end
        ST_OUT_GRANT: begin
          if (out_beat && w_tc && in_req) begin
            state_d = ST_TURN_IN;
            turn_d  = TURN_LOAD;
          end else if (!out_req && !out_beat) begin
            state_d = ST_IDLE;
          end
        end
        ST_TURN_OUT: begin
          if (turn_q == '0) begin
            state_d = ST_OUT_GRANT;
            dir_d   = DIR_OUT;
          end else begin
            turn_d = turn_q - TW'(1);
          end
        end
        ST_TURN_IN: begin
          if (turn_q == '0) begin
            state_d = ST_IN_GRANT;
            dir_d   = DIR_IN;
          end else begin
            turn_d = turn_q - TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          dir_d   = DIR_IN;
          turn_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    in_grant_d  = (state_d == ST_IN_GRANT);
    out_grant_d = (state_d == ST_OUT_GRANT);
    turn_flag_d = (state_d == ST_TURN_OUT) || (state_d == ST_TURN_IN);
    case (state_d)
      ST_OUT_GRANT,
      ST_TURN_OUT,
      ST_TURN_IN:  drive_d = 1'b1;
      ST_IN_GRANT: drive_d = 1'b0;
      default:     drive_d = (dir_d == DIR_OUT);
    endcase
    perr_d = perr_q
           | (in_beat && !in_grant_q)
           | (out_beat && !out_grant_q)
           | (in_beat && out_beat);
  end

  assign in_grant         = in_grant_q;
  assign out_grant        = out_grant_q;
  assign dut_driving_cons = drive_q;
  assign turnaround       = turn_flag_q;
  assign beat_cnt         = w_cnt;
  assign protocol_err     = perr_q;

endmodule : con_bus_arbiter

`default_nettype wire

// File: tb/tb_con_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_con_bus_arbiter : directed scoreboard bench for con_bus_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_con_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       running = 1'b0;
  logic       in_req = 1'b0;
  logic       in_beat = 1'b0;
  logic       out_req = 1'b0;
  logic       out_beat = 1'b0;

  logic       in_grant, out_grant, dut_driving_cons, turnaround, protocol_err;
  logic [4:0] beat_cnt;
  logic       in_grant0, out_grant0, drv0, turnaround0, perr0;
  logic [4:0] beat_cnt0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  con_bus_arbiter #(
    .MAX_BURST         (16),
    .TURNAROUND_CYCLES (2),
    .OUT_PRIORITY      (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .running          (running),
    .in_req           (in_req),
    .in_beat          (in_beat),
    .out_req          (out_req),
    .out_beat         (out_beat),
    .in_grant         (in_grant),
    .out_grant        (out_grant),
    .dut_driving_cons (dut_driving_cons),
    .turnaround       (turnaround),
    .beat_cnt         (beat_cnt),
    .protocol_err     (protocol_err)
  );

  con_bus_arbiter #(
    .MAX_BURST         (16),
    .TURNAROUND_CYCLES (2),
    .OUT_PRIORITY      (1'b0)
  ) dut0 (
    .clk              (clk),
    .rst              (rst),
    .running          (running),
    .in_req           (in_req),
    .in_beat          (in_beat),
    .out_req          (out_req),
    .out_beat         (out_beat),
    .in_grant         (in_grant0),
    .out_grant        (out_grant0),
    .dut_driving_cons (drv0),
    .turnaround       (turnaround0),
    .beat_cnt         (beat_cnt0),
    .protocol_err     (perr0)
  );

  // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
  task automatic step(input string tag,
                      input logic r, input logic ir, input logic ib,
                      input logic orq, input logic ob,
                      input logic ig, input logic og, input logic drv,
                      input logic ta, input int cnt, input logic pe);
    exp_t       e;
    exp_t       got;
    logic [9:0] obs;
    running  = r;
    in_req   = ir;
    in_beat  = ib;
    out_req  = orq;
    out_beat = ob;
    e.tag = tag;
    e.v   = {ig, og, drv, ta, 5'(cnt), pe};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    obs = {in_grant, out_grant, dut_driving_cons, turnaround, beat_cnt, protocol_err};
    checks++;
    assert (obs === got.v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed ig/og/drv/ta/cnt/perr=%b required %b", got.tag, obs, got.v);
    end
  endtask

  task automatic check0(input string tag, input logic ig, input logic ta);
    checks++;
    assert ({in_grant0, turnaround0} === {ig, ta}) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed grant/turn=%b%b required %b%b", tag, in_grant0, turnaround0, ig, ta);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and quiet idle
    rst = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Inbound only: wraps twice, then a req drop coinciding with a beat
    step("in_grant", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) step("in_beat", 1, 1, 1, 0, 0, 1, 0, 0, 0, k % 16, 0);
    step("in_drop_beat", 1, 0, 1, 0, 0, 1, 0, 0, 0, 9, 0);
    step("in_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fairness with two dead cycles each way
    step("fair_ig", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++)
      step("fair_in", 1, 1, 1, (k >= 5), 0, 1, 0, 0, 0, k, 0);
    step("fair_to_out", 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    step("fair_turn2", 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    step("fair_og", 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) step("fair_out", 1, 1, 0, 1, 1, 0, 1, 1, 0, k, 0);
    step("fair_to_in", 1, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0);
    step("fair_turn_in2", 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    step("fair_ig2", 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("fair_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Tie from IDLE; dut0 has inbound priority
    rst = 1'b1;
    step("tie_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("tie_turn1", 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    check0("tie0_ig1", 1'b1, 1'b0);
    step("tie_turn2", 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    check0("tie0_ig2", 1'b1, 1'b0);
    step("tie_og", 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);

    // running drop mid outbound burst, then immediate inbound regrant
    for (int k = 1; k <= 6; k++) step("run_out", 1, 1, 0, 1, 1, 0, 1, 1, 0, k, 0);
    step("run_drop", 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step("run_regrant", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("run_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Protocol error: inbound beat while outbound owns the bus
    step("perr_turn1", 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    step("perr_turn2", 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    step("perr_og", 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    step("perr_set", 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("perr_sticky", 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
    rst = 1'b1;
    step("perr_clr", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_con_bus_arbiter

`default_nettype wire
